// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential MEM-stage data-bus engine.
// Takes one load/store at a time, lane-aligns store data and strobes, runs the
// dbus valid/addr_ok/data_ok handshake and extends load data for the W stage.
//
// state | meaning
// IDLE  | ready for a new request
// ADDR  | address phase on dbus, waiting for dresp_addr_ok
// DATA  | address accepted, waiting for dresp_data_ok
// RSP   | one-cycle completion pulse
// MIS   | misaligned request, one-cycle error response
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_misalign,
  output logic                stall,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RSP, S_MIS} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              store_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] raw_q;
  logic              flushed_q;

  logic              accept;
  logic              misalign;
  logic              capture;
  logic              set_flush;
  logic              in_addr;
  logic [LB-1:0]     off;
  logic [NB-1:0]     lane_base;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] top_bit;
  logic [DATA_W-1:0] load_ext;

  // accept is masked by reset so every output reads 0 (except ready) during reset
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready & ~flush & ~reset;
  assign stall     = (state != S_IDLE) | accept;
  assign in_addr   = (state == S_ADDR);
  assign off       = addr_q[LB-1:0];

  // misalignment of the incoming request; 8-byte accesses need a 64-bit bus
  always_comb begin
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  // next-state logic; a flush seen after addr_ok lets the bus drain but skips RSP
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    set_flush = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = misalign ? S_MIS : S_ADDR;
      S_ADDR: begin
        if (dresp_addr_ok) begin
          set_flush = flush;
          if (dresp_data_ok) begin
            capture   = 1'b1;
            state_nxt = flush ? S_IDLE : S_RSP;
          end else begin
            state_nxt = S_DATA;
          end
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        set_flush = flush;
        if (dresp_data_ok) begin
          capture   = 1'b1;
          state_nxt = (flushed_q | flush) ? S_IDLE : S_RSP;
        end
      end
      S_RSP, S_MIS: state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // request latch, load data capture and sticky flush flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      store_q   <= 1'b0;
      wdata_q   <= '0;
      raw_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        signed_q <= req_signed;
        store_q  <= req_store;
        wdata_q  <= req_wdata;
      end
      if (capture) raw_q <= store_q ? '0 : dresp_data;
      if (state_nxt == S_IDLE) flushed_q <= 1'b0;
      else if (set_flush)      flushed_q <= 1'b1;
    end
  end

  // byte-enable pattern before lane shifting
  always_comb begin
    case (size_q)
      2'd0:    lane_base = NB'(1);
      2'd1:    lane_base = NB'(3);
      2'd2:    lane_base = NB'(15);
      default: lane_base = '1;
    endcase
  end

  // load extraction: shift lane down, keep 8<<size bits, extend from the top kept bit
  always_comb begin
    shifted = raw_q >> {off, 3'b000};
    case (size_q)
      2'd0:    keep_mask = DATA_W'(8'hFF);
      2'd1:    keep_mask = DATA_W'(16'hFFFF);
      2'd2:    keep_mask = DATA_W'(32'hFFFF_FFFF);
      default: keep_mask = '1;
    endcase
    top_bit  = keep_mask ^ (keep_mask >> 1);
    load_ext = shifted & keep_mask;
    if (signed_q && |(shifted & top_bit)) load_ext = load_ext | ~keep_mask;
  end

  assign dreq_valid    = in_addr;
  assign dreq_addr     = in_addr ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign dreq_strobe   = (in_addr & store_q) ? (lane_base << off) : '0;
  assign dreq_data     = (in_addr & store_q) ? (wdata_q << {off, 3'b000}) : '0;
  assign resp_valid    = (state == S_RSP) | (state == S_MIS);
  assign resp_misalign = (state == S_MIS);
  assign resp_rdata    = (state == S_RSP) ? load_ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance share stimulus;
// expected values come from a byte-level reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid32, req_valid64;
  logic        req_store, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  logic        ready32, rv32, mis32, stall32, dv32;
  logic [31:0] rdata32, daddr32, ddata32;
  logic [3:0]  strb32;
  logic        ready64, rv64, mis64, stall64, dv64;
  logic [63:0] rdata64, ddata64;
  logic [31:0] daddr64;
  logic [7:0]  strb64;

  logic        sel64;
  logic        o_ready, o_rv, o_mis, o_stall, o_dv;
  logic [63:0] o_rdata, o_ddata;
  logic [31:0] o_daddr;
  logic [7:0]  o_strb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid32), .req_ready(ready32),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush),
    .resp_valid(rv32), .resp_rdata(rdata32), .resp_misalign(mis32), .stall(stall32),
    .dreq_valid(dv32), .dreq_addr(daddr32), .dreq_strobe(strb32), .dreq_data(ddata32),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data[31:0])
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid64), .req_ready(ready64),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(rv64), .resp_rdata(rdata64), .resp_misalign(mis64), .stall(stall64),
    .dreq_valid(dv64), .dreq_addr(daddr64), .dreq_strobe(strb64), .dreq_data(ddata64),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  // view of whichever instance is under test
  always_comb begin
    if (sel64) begin
      o_ready = ready64; o_rv = rv64; o_mis = mis64; o_stall = stall64; o_dv = dv64;
      o_rdata = rdata64; o_ddata = ddata64; o_daddr = daddr64; o_strb = strb64;
    end else begin
      o_ready = ready32; o_rv = rv32; o_mis = mis32; o_stall = stall32; o_dv = dv32;
      o_rdata = {32'd0, rdata32}; o_ddata = {32'd0, ddata32}; o_daddr = daddr32;
      o_strb = {4'd0, strb32};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // load result from the byte rules: pick the lane, keep 8<<sz bits, extend to w bits
  function automatic logic [63:0] exp_load(input logic [63:0] raw, input logic [31:0] a,
                                           input int sz, input bit sg, input int w);
    int nb, off, nbits;
    logic [63:0] v;
    nb = w / 8;
    off = int'(a % nb);
    nbits = 8 << sz;
    v = raw >> (8 * off);
    if (nbits < 64) begin
      v = v % (64'd1 << nbits);
      if (sg && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
    end
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic clear_bus();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = {$urandom, $urandom};
    flush = 1'b0;
  endtask

  // fl: 0 none, 1 flush in ADDR before addr_ok, 2 flush in DATA, 3 flush with addr_ok
  task automatic run_txn(input bit w64, input bit st, input int sz, input bit sg,
                         input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                         input int aok_dly, input int dok_dly, input int fl);
    int w, nb, off, nbytes;
    bit mis, last;
    logic [63:0] wmask, wd_e, rd_e, ed, es, er;
    w = w64 ? 64 : 32;
    nb = w / 8;
    off = int'(a % nb);
    nbytes = 1 << sz;
    mis = ((a % nbytes) != 0) || (nbytes > nb);
    wmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wd_e = wd & wmask;
    rd_e = rd & wmask;
    ed = st ? ((wd_e << (8 * off)) & wmask) : 64'd0;
    es = 64'd0;
    if (st) for (int b = 0; b < nb; b++) if (b >= off && b < off + nbytes) es = es | (64'd1 << b);
    er = st ? 64'd0 : exp_load(rd_e, a, sz, sg, w);
    sel64 = w64;

    @(negedge clk);
    if (w64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
    req_store = st; req_size = 2'(sz); req_signed = sg; req_addr = a; req_wdata = wd;
    clear_bus();
    #1;
    chk("accept_ready", {63'd0, o_ready}, 64'd1);
    chk("accept_stall", {63'd0, o_stall}, 64'd1);
    @(negedge clk);
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom_range(0, 3)); req_store = 1'($urandom); req_signed = 1'($urandom);

    if (mis) begin
      #1;
      chk("mis_valid", {63'd0, o_rv}, 64'd1);
      chk("mis_flag", {63'd0, o_mis}, 64'd1);
      chk("mis_rdata", o_rdata, 64'd0);
      chk("mis_no_dreq", {63'd0, o_dv}, 64'd0);
      @(negedge clk); #1;
      chk("mis_done_valid", {63'd0, o_rv}, 64'd0);
      chk("mis_done_ready", {63'd0, o_ready}, 64'd1);
      return;
    end

    for (int k = 0; k <= aok_dly; k++) begin
      if (k > 0) @(negedge clk);
      last = (k == aok_dly);
      dresp_addr_ok = last && (fl != 1);
      dresp_data_ok = last && (fl != 1) && (dok_dly == 0);
      dresp_data = dresp_data_ok ? rd : {$urandom, $urandom};
      flush = last && (fl == 1 || fl == 3);
      #1;
      chk("addr_dv", {63'd0, o_dv}, 64'd1);
      chk("addr_daddr", {32'd0, o_daddr}, {32'd0, a & ~32'(nb - 1)});
      chk("addr_strobe", {56'd0, o_strb}, es);
      chk("addr_ddata", o_ddata, ed);
      chk("addr_stall", {63'd0, o_stall}, 64'd1);
      chk("addr_no_resp", {63'd0, o_rv}, 64'd0);
    end

    if (fl == 1) begin
      @(negedge clk); clear_bus(); #1;
      chk("flush_addr_idle", {63'd0, o_ready}, 64'd1);
      chk("flush_addr_noresp", {63'd0, o_rv}, 64'd0);
      chk("flush_addr_nodv", {63'd0, o_dv}, 64'd0);
      return;
    end

    for (int k = 1; k <= dok_dly; k++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (k == dok_dly);
      dresp_data = dresp_data_ok ? rd : {$urandom, $urandom};
      flush = (fl == 2) && (k == 1);
      #1;
      chk("data_dv", {63'd0, o_dv}, 64'd0);
      chk("data_stall", {63'd0, o_stall}, 64'd1);
      chk("data_no_resp", {63'd0, o_rv}, 64'd0);
    end

    @(negedge clk); clear_bus(); #1;
    if (fl >= 2) begin
      chk("drain_noresp", {63'd0, o_rv}, 64'd0);
      @(negedge clk); #1;
      chk("drain_noresp2", {63'd0, o_rv}, 64'd0);
      chk("drain_idle", {63'd0, o_ready}, 64'd1);
    end else begin
      chk("resp_valid", {63'd0, o_rv}, 64'd1);
      chk("resp_mis", {63'd0, o_mis}, 64'd0);
      chk("resp_rdata", o_rdata, er);
      chk("resp_stall", {63'd0, o_stall}, 64'd1);
      chk("resp_not_ready", {63'd0, o_ready}, 64'd0);
      @(negedge clk); #1;
      chk("post_valid", {63'd0, o_rv}, 64'd0);
      chk("post_ready", {63'd0, o_ready}, 64'd1);
      chk("post_stall", {63'd0, o_stall}, 64'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    chk({tag, "_rv"}, {63'd0, o_rv}, 64'd0);
    chk({tag, "_mis"}, {63'd0, o_mis}, 64'd0);
    chk({tag, "_stall"}, {63'd0, o_stall}, 64'd0);
    chk({tag, "_dv"}, {63'd0, o_dv}, 64'd0);
    chk({tag, "_rdata"}, o_rdata, 64'd0);
    chk({tag, "_daddr"}, {32'd0, o_daddr}, 64'd0);
    chk({tag, "_strb"}, {56'd0, o_strb}, 64'd0);
    chk({tag, "_ddata"}, o_ddata, 64'd0);
  endtask

  initial begin
    bit          r_w64, r_st, r_sg;
    int          r_sz, r_fl, r_aok, r_dok;
    logic [31:0] r_a;

    reset = 1'b1; sel64 = 1'b0;
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    clear_bus();
    #12;
    sel64 = 1'b0; #1 chk_reset_outputs("rst32");
    sel64 = 1'b1; #1 chk_reset_outputs("rst64");
    @(negedge clk); reset = 1'b0;

    run_txn(0, 0, 2, 0, 32'h1004, 64'd0, 64'hDEAD_BEEF, 2, 1, 0);
    run_txn(0, 0, 0, 1, 32'h1003, 64'd0, 64'h80FF_0000, 0, 1, 0);
    run_txn(0, 0, 0, 0, 32'h1003, 64'd0, 64'h80FF_0000, 1, 0, 0);
    run_txn(0, 1, 1, 0, 32'h2002, 64'h0000_ABCD, 64'd0, 3, 1, 0);
    run_txn(0, 0, 2, 0, 32'h3001, 64'd0, 64'd0, 0, 0, 0);
    run_txn(0, 0, 3, 0, 32'h3000, 64'd0, 64'd0, 0, 0, 0);
    run_txn(0, 0, 2, 0, 32'h4000, 64'd0, 64'h1234_5678, 2, 1, 1);
    run_txn(0, 0, 2, 0, 32'h4000, 64'd0, 64'h1234_5678, 0, 2, 2);
    run_txn(0, 1, 2, 0, 32'h4004, 64'h5555_AAAA, 64'd0, 1, 2, 3);
    run_txn(1, 0, 3, 0, 32'h0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    run_txn(1, 0, 2, 1, 32'h000C, 64'd0, 64'h8765_4321_0000_0000, 1, 1, 0);
    run_txn(1, 1, 0, 0, 32'h0107, 64'h0000_00A5, 64'd0, 0, 1, 0);

    // reset while the 64-bit unit sits in DATA
    sel64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b1; req_store = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 32'h8;
    @(negedge clk);
    req_valid64 = 1'b0; dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0; reset = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(negedge clk); reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk); clear_bus(); #1;
    chk("rst_abandon_rv", {63'd0, o_rv}, 64'd0);
    chk("rst_abandon_ready", {63'd0, o_ready}, 64'd1);

    for (int i = 0; i < 250; i++) begin
      r_w64 = 1'($urandom);
      r_st  = 1'($urandom);
      r_sg  = 1'($urandom);
      r_sz  = r_w64 ? $urandom_range(0, 3) : $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) r_sz = 3;
      r_a   = $urandom;
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((32'd1 << r_sz) - 32'd1);
      r_fl  = $urandom_range(0, 7);
      if (r_fl > 3) r_fl = 0;
      r_aok = $urandom_range(0, 3);
      r_dok = $urandom_range(0, 3);
      if (r_fl >= 2 && r_dok == 0) r_dok = 1;
      run_txn(r_w64, r_st, r_sz, r_sg, r_a, {$urandom, $urandom}, {$urandom, $urandom},
              r_aok, r_dok, r_fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
